// File: rtl/stages_definition_pkg.sv
// Shared definitions for the PDA run controller: run-state encoding and display width.
package stages_definition_pkg;

  localparam int unsigned DISPLAY_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_STEP,
    ST_DONE
  } run_state_t;

endpackage

// File: rtl/pda_capture_fifo.sv
// First-word-fall-through capture FIFO with synchronous clear and sticky overflow flag.
module pda_capture_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      mem      <= '{default: '0};
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pda_run_controller.sv
// Drives PDA core reset/halt through reset, free-run or single-step runs with a cycle budget,
// and captures every change of the memory-display word into a FIFO.
module pda_run_controller
  import stages_definition_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     cycle_limit,
  input  logic [DISPLAY_W-1:0] mem_display,
  output logic                 core_reset,
  output logic                 halt,
  output logic [CNT_W-1:0]     cycles,
  output logic                 done,
  input  logic                 rd_en,
  output logic [DISPLAY_W-1:0] rd_data,
  output logic                 empty,
  output logic                 overflow
);

  localparam int unsigned     RC_W    = $clog2(RST_CYCLES + 1);
  localparam int unsigned     CW1     = CNT_W + 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  run_state_t           state;
  logic [RC_W-1:0]      rst_cnt;
  logic                 mode_step;
  logic [CNT_W-1:0]     limit;
  logic [DISPLAY_W-1:0] last_display;
  logic                 active;
  logic                 executing;
  logic                 limit_hit;
  logic                 capture;
  logic                 fifo_clear;
  logic                 unused_full;
  logic [CNT_W-1:0]     cycles_next;

  assign active      = (state == ST_RUN) || (state == ST_STEP);
  // halt is registered, so a low halt in RUN/STEP means the core executes this cycle.
  assign executing   = active && !halt;
  assign cycles_next = (&cycles) ? cycles : cycles + CNT_W'(1);
  assign limit_hit   = (limit != '0) && (CW1'(cycles) + CW1'(1) == CW1'(limit));
  assign capture     = active && (mem_display != last_display);
  assign fifo_clear  = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      core_reset   <= 1'b1;
      halt         <= 1'b1;
      cycles       <= '0;
      done         <= 1'b0;
      rst_cnt      <= '0;
      mode_step    <= 1'b0;
      limit        <= '0;
      last_display <= '0;
    end else begin
      if (capture) begin
        last_display <= mem_display;
      end
      if (executing) begin
        cycles <= cycles_next;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RST;
            core_reset <= 1'b1;
            halt       <= 1'b1;
            done       <= 1'b0;
            cycles     <= '0;
            rst_cnt    <= '0;
            mode_step  <= step_mode;
            limit      <= cycle_limit;
          end
        end
        ST_RST: begin
          if (abort) begin
            state      <= ST_DONE;
            core_reset <= 1'b0;
            halt       <= 1'b1;
            done       <= 1'b1;
          end else if (rst_cnt == RC_LAST) begin
            state        <= mode_step ? ST_STEP : ST_RUN;
            core_reset   <= 1'b0;
            halt         <= mode_step;
            last_display <= mem_display;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        ST_RUN: begin
          if (abort || limit_hit) begin
            state <= ST_DONE;
            halt  <= 1'b1;
            done  <= 1'b1;
          end
        end
        ST_STEP: begin
          // Step pulses seen while the one-cycle window is open are dropped.
          if (abort || (!halt && limit_hit)) begin
            state <= ST_DONE;
            halt  <= 1'b1;
            done  <= 1'b1;
          end else if (!halt) begin
            halt <= 1'b1;
          end else if (step) begin
            halt <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pda_capture_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DISPLAY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (fifo_clear),
    .push     (capture),
    .push_data(mem_display),
    .pop      (rd_en),
    .head     (rd_data),
    .empty    (empty),
    .full     (unused_full),
    .overflow (overflow)
  );

endmodule

// File: doc/pda_run_controller.md
Name: pda_run_controller

Overview:
- Synthesizable controller that drives the PDA core's run-control inputs (core reset, halt) and observes its 32-bit memory-display output.
- Sequences the core through reset, free-run or single-step execution, and stops it after a programmable cycle budget.
- Captures every change of the display word into a small FIFO that a host or debug port can drain.
- Sits beside the PDA top level, in place of a bench-only stimulus driver.

Parameters:
- RST_CYCLES, 4, number of cycles core_reset is held high after start.
- CNT_W, 17, width of the cycle counter and cycle_limit.
- DEPTH, 8, capture FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous active-low reset; 0 = reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- step_mode  in  1  sampled at start; 1 = single-step, 0 = free-run.
- step  in  1  one-cycle pulse; in single-step mode, releases exactly one core cycle.
- abort  in  1  forces DONE from any non-IDLE state.
- cycle_limit  in  CNT_W  run budget in executed core cycles; 0 = unlimited.
- mem_display  in  32  PDA memory-display output.
- core_reset  out  1  active-high reset to the PDA.
- halt  out  1  active-high halt to the PDA.
- cycles  out  CNT_W  executed core cycles since the last start.
- done  out  1  high in DONE.
- rd_en  in  1  pop request for the capture FIFO.
- rd_data  out  32  FIFO head; valid when empty = 0.
- empty  out  1  FIFO empty.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Reset values (reset = 0), all asynchronous:
  - state = IDLE, core_reset = 1, halt = 1, cycles = 0, done = 0.
  - FIFO emptied: empty = 1, rd_data = 0, overflow = 0.
  - last_display = 0.
- States: IDLE, RST, RUN, STEP, DONE.
- IDLE: core_reset = 1, halt = 1.
  - On start, go to RST.
  - Latch step_mode and cycle_limit.
  - Clear cycles, overflow and the FIFO.
- RST: core_reset = 1, halt = 1 for exactly RST_CYCLES cycles, using an internal counter.
  - Then go to RUN if step_mode = 0, or STEP if step_mode = 1.
  - Latch last_display <= mem_display on the exit cycle.
- RUN: core_reset = 0, halt = 0. Each cycle in RUN, cycles increments by 1.
  - When the latched limit is nonzero and cycles + 1 == limit, the next state is DONE.
  - halt is registered high in the same edge as the transition, so exactly limit core cycles execute.
- STEP: core_reset = 0, halt = 1 except in the single cycle after a step pulse, where halt = 0 and cycles increments.
  - The limit check is the same as RUN.
  - step pulses arriving while halt = 0 are ignored; there is no queueing.
- DONE: core_reset = 0, halt = 1, done = 1; core state is preserved.
  - On start, go to RST; this re-clears cycles, FIFO and overflow.
- abort has priority over all other transitions. From RST, RUN or STEP, the next state is DONE. abort is ignored in IDLE and DONE.
- Unlimited run (limit = 0): cycles saturates at all-ones and does not wrap. The run continues until abort.
- Capture: in RUN and STEP, when mem_display != last_display, push mem_display and update last_display. At most one push per cycle; no capture in IDLE, RST or DONE.
- FIFO:
  - First-word-fall-through: rd_data shows the head combinationally from storage.
  - Pop on rd_en && !empty. rd_en while empty is ignored.
  - Push while full is dropped and sets overflow.
  - Simultaneous push and pop when full: both succeed, count unchanged, overflow not set.
  - Simultaneous push and pop when empty: push only.
- start while in RST, RUN or STEP is ignored.

Decomposition:
- Shared package stages_definition_pkg gains:
  - run_state_t (enum of the five states);
  - constant DISPLAY_W = 32.
- One sub-module, pda_capture_fifo:
  - parameterized DEPTH and width;
  - push/pop/clear interface;
  - empty, full and overflow outputs;
  - same clk and reset.

Test Plan:
1. Reset mid-RUN (reset = 0 at cycle 10 of a run) -> next edge-independent: core_reset = 1, halt = 1, cycles = 0, empty = 1, state IDLE.
2. start, step_mode = 0, cycle_limit = 70, constant mem_display -> core_reset high exactly 4 cycles; halt low exactly 70 cycles; cycles = 70, done = 1; FIFO empty.
3. Single-step, limit = 3 -> 5 step pulses spaced 4 cycles apart give 3 one-cycle halt-low windows, then done = 1. A step pulse during the low window is ignored.
4. Free-run, mem_display changes 0 -> 0xA -> 0xA -> 0xB -> 0x0 -> drain gives 0xA, 0xB, 0x0; then empty = 1, overflow = 0.
5. DEPTH = 8 with 10 distinct display changes and no reads -> 8 entries (first 8 values), overflow = 1. Push+pop on a full FIFO keeps count 8.
6. limit = 0 with abort at cycle 25 -> DONE next cycle, halt = 1, cycles = 25. A subsequent start restarts at RST with cycles = 0.
